klp32_trace_tx: RTL and testbench
=================================

# klp32_trace_tx

Debug-trace transmitter for the KLP32 single-cycle core. Captures one trace record per clock in which capture is enabled (PC, instruction, write-back data, ALU result, register/memory write strobes), buffers records in a small FIFO, and serializes them as a byte stream over a valid/ready interface toward a UART TX or host link. Sits beside the core, fed directly by the core's debug output signals.

## Interface
- DEPTH, 8, FIFO depth in records; power of two, ≥2
- clk  input  1  rising-edge clock, shared with core
- reset  input  1  synchronous, active-low
- i_capture_en  input  1  capture a record this cycle
- i_pc  input  32  PC value presented by core
- i_inst  input  32  instruction word
- i_writeBack  input  32  register write-back data
- i_aluOut  input  32  ALU result
- i_RegWEn  input  1  register write enable
- i_memRW  input  1  data memory write enable
- o_tx_data  output  8  stream byte
- o_tx_valid  output  1  o_tx_data valid
- i_tx_ready  input  1  sink accepts byte
- o_overflow  output  1  sticky: at least one record dropped
- o_count  output  $clog2(DEPTH)+1  records held in FIFO

## Operation
- Record byte order: header, then i_pc, i_inst, i_writeBack, i_aluOut, each little-endian (LSB first). 17 bytes.
- Header = {4'hA, 1'b0, lost, memRW, RegWEn}; lost=1 if ≥1 record dropped since previous stored record.
- Push: i_capture_en=1 and FIFO not full (pre-edge count < DEPTH) → record written. Full → record dropped, o_overflow set, lost-pending set. Push when full is dropped even if a pop occurs the same edge.
- lost-pending cleared when next record is stored (that record carries lost=1).
- Serializer FSM: IDLE → LOAD → SEND.
  - IDLE: o_tx_valid=0; if FIFO non-empty, pop head into 136-bit shift register, go SEND.
  - SEND: o_tx_valid=1, o_tx_data = current byte; on valid&&ready advance byte index 0..16. Byte 16 accepted: if FIFO non-empty, pop and remain SEND with index 0 (back-to-back, no bubble); else IDLE.
  - LOAD is merged into the IDLE→SEND transition (no extra cycle).
- o_tx_data and o_tx_valid stable while o_tx_valid=1 and i_tx_ready=0; valid never drops mid-record.
- i_tx_ready ignored when o_tx_valid=0.
- o_count counts FIFO contents only (not the record in the shift register); simultaneous push and pop leaves count unchanged.

## Timing
- Reset (reset=0 at edge): FIFO empty, o_count=0, o_overflow=0, lost-pending=0, FSM IDLE, o_tx_valid=0, o_tx_data=8'h00, byte index 0.
- Reset mid-record aborts immediately; partial record not resumed.
- Capture at edge N → o_count increments after N → popped at edge N+1 (if FSM IDLE) → o_tx_valid=1 with header from cycle after N+1.
- With i_tx_ready held 1: one byte per cycle, 17 cycles per record, continuous across records.
- o_overflow cleared only by reset.

## Configuration
- KLP32_TRACE_ALUOUT_EN defined: record includes i_aluOut; 17 bytes; header bit 3 = 0.
- Undefined: i_aluOut ignored and not stored (FIFO width 99 bits); record 13 bytes; all other rules identical.

## Structure
- Package klp32_trace_pkg: trace_entry_t struct (flags, pc, inst, wb, alu), TRACE_SYNC = 4'hA, TRACE_RECORD_BYTES (17 or 13 under the macro), FSM state enum.
- Sub-module klp32_trace_fifo: synchronous FIFO of trace_entry_t, push/pop/full/empty/count, same clk/reset.
- Top holds lost/overflow logic, serializer FSM, byte mux.

## Test plan
- Single capture pc=0x00000004, inst=0x00500093, wb=0x5, alu=0x5, RegWEn=1, ready=1 → bytes A1 04 00 00 00 93 00 50 00 05 00 00 00 05 00 00 00, valid low after.
- Ready toggled 1/0 every cycle during record → each byte held while ready=0; 17 bytes in order, none duplicated.
- 12 consecutive captures, DEPTH=8, ready=0 → o_count=8, o_overflow=1; next stored record header bit 2 =1, earlier ones 0.
- Two records queued, ready=1 → 34 consecutive valid cycles, header of second immediately after byte 16 of first.
- Reset asserted at byte 5 of record → o_tx_valid=0, o_count=0, o_overflow=0 next cycle; fresh capture emits header first.
- Macro undefined → same stimulus as first scenario yields 13 bytes ending 05 00 00 00.

Source files
------------

// File: rtl/klp32_trace_pkg.sv
// Shared types and constants for the KLP32 debug-trace transmitter.
// Latency: n/a (types, constants and one pure packing function).
// Backpressure: n/a.
//
// Optional feature macro: KLP32_TRACE_ALUOUT_EN
//   defined   -> records carry the ALU result (17-byte record)
//   undefined -> ALU result is not stored (13-byte record, 99-bit entry)
package klp32_trace_pkg;

    // Upper nibble of every header byte, lets a host resynchronise on the stream.
    localparam logic [3:0] TRACE_SYNC = 4'hA;

`ifdef KLP32_TRACE_ALUOUT_EN
    localparam int TRACE_RECORD_BYTES = 17;
`else
    localparam int TRACE_RECORD_BYTES = 13;
`endif

    localparam int TRACE_RECORD_BITS = TRACE_RECORD_BYTES * 8;

    // Wide enough to hold byte indices 0..16.
    localparam int TRACE_IDX_W = 5;

    typedef struct packed {
        logic lost;     // one or more records dropped before this one
        logic mem_rw;   // data memory write strobe
        logic reg_wen;  // register file write strobe
    } trace_flags_t;

    typedef struct packed {
        trace_flags_t flags;
        logic [31:0]  pc;
        logic [31:0]  inst;
        logic [31:0]  wb;
`ifdef KLP32_TRACE_ALUOUT_EN
        logic [31:0]  alu;
`endif
    } trace_entry_t;

    // LOAD exists as a named state for readability of the state diagram, but
    // the load happens on the IDLE->SEND edge so the FSM never rests in it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

    // Lay a record out so that byte 0 (the header) sits in the low bits and the
    // serializer can simply shift right by one byte per accepted beat. Each
    // 32-bit field therefore goes out least-significant byte first.
    function automatic logic [TRACE_RECORD_BITS-1:0] trace_pack(input trace_entry_t e);
        logic [7:0] hdr;
        hdr = {TRACE_SYNC, 1'b0, e.flags.lost, e.flags.mem_rw, e.flags.reg_wen};
`ifdef KLP32_TRACE_ALUOUT_EN
        return {e.alu, e.wb, e.inst, e.pc, hdr};
`else
        return {e.wb, e.inst, e.pc, hdr};
`endif
    endfunction

endpackage

// File: rtl/klp32_trace_fifo.sv
// Synchronous FIFO of trace_entry_t records for the trace transmitter.
// Latency: a pushed record is visible at o_head (and in o_count) the cycle after the push edge.
// Backpressure: push while full is ignored; pop while empty is ignored; push+pop same edge keeps count.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   i_push, i_push_dat    write request and record
//   i_pop                 read request (head advances on the edge)
//   o_head                current head record (valid when !o_empty)
//   o_full, o_empty       occupancy flags from the pre-edge count
//   o_count               records held, 0..DEPTH
module klp32_trace_fifo
    import klp32_trace_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  trace_entry_t  i_push_dat,
    input  logic          i_pop,
    output trace_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    trace_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;

    // Full/empty come from the registered count, so a push into a full FIFO
    // is refused even if the same edge pops an entry.
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage carries no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/klp32_trace_tx.sv
// Debug-trace transmitter: captures one core trace record per enabled cycle and streams it as bytes.
// Latency: capture at edge N -> popped at N+1 (when idle) -> header byte valid after edge N+1.
// Backpressure: byte held stable while i_tx_ready=0; FIFO full drops records and sets sticky o_overflow.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-low reset
//   i_capture_en                    capture a record this cycle
//   i_pc, i_inst, i_writeBack,      core debug fields
//   i_aluOut, i_RegWEn, i_memRW
//   o_tx_data, o_tx_valid,          byte stream, valid/ready handshake
//   i_tx_ready
//   o_overflow                      sticky: at least one record dropped since reset
//   o_count                         records waiting in the FIFO (excludes the one being sent)
//
// Optional feature macro: KLP32_TRACE_ALUOUT_EN (include i_aluOut; 17-byte records,
// otherwise i_aluOut is ignored and records are 13 bytes).
module klp32_trace_tx
    import klp32_trace_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_capture_en,
    input  logic [31:0]   i_pc,
    input  logic [31:0]   i_inst,
    input  logic [31:0]   i_writeBack,
    input  logic [31:0]   i_aluOut,
    input  logic          i_RegWEn,
    input  logic          i_memRW,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_overflow,
    output logic [CW-1:0] o_count
);

    localparam logic [TRACE_IDX_W-1:0] LAST_IDX = TRACE_IDX_W'(TRACE_RECORD_BYTES - 1);

    trace_entry_t                 w_entry;
    trace_entry_t                 w_head;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_byte_acc;
    logic                         w_last_byte;

    tx_state_t                    r_state;
    logic [TRACE_RECORD_BITS-1:0] r_shift;
    logic [TRACE_IDX_W-1:0]       r_idx;
    logic                         r_valid;
    logic                         r_lost_pend;
    logic                         r_overflow;

    // ------------------------------------------------------------------
    // Record assembly
    // ------------------------------------------------------------------
    always_comb begin
        w_entry               = '0;
        w_entry.flags.lost    = r_lost_pend;
        w_entry.flags.mem_rw  = i_memRW;
        w_entry.flags.reg_wen = i_RegWEn;
        w_entry.pc            = i_pc;
        w_entry.inst          = i_inst;
        w_entry.wb            = i_writeBack;
`ifdef KLP32_TRACE_ALUOUT_EN
        w_entry.alu           = i_aluOut;
`endif
    end

`ifndef KLP32_TRACE_ALUOUT_EN
    // The ALU result is deliberately not recorded in this build.
    logic w_unused_alu;
    assign w_unused_alu = ^i_aluOut;
`endif

    assign w_push = i_capture_en && !w_full;

    // ------------------------------------------------------------------
    // Record buffer
    // ------------------------------------------------------------------
    klp32_trace_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (o_count)
    );

    // ------------------------------------------------------------------
    // Drop tracking
    // ------------------------------------------------------------------
    // lost-pending marks the next stored record so the host can tell that
    // the stream has a gap in front of it; o_overflow only ever rises.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lost_pend <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (i_capture_en) begin
            if (w_full) begin
                r_lost_pend <= 1'b1;
                r_overflow  <= 1'b1;
            end else begin
                r_lost_pend <= 1'b0;
            end
        end
    end

    assign o_overflow = r_overflow;

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    // r_valid is high exactly while in SEND, so the sink's ready is only
    // looked at when a byte is actually on offer.
    assign w_byte_acc  = r_valid && i_tx_ready;
    assign w_last_byte = (r_idx == LAST_IDX);

    // Pop when idle with data waiting, or on acceptance of the last byte so
    // the next header follows without a bubble.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty;
            ST_SEND: w_pop = w_byte_acc && w_last_byte && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= trace_pack(w_head);
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_byte_acc) begin
                        if (w_last_byte) begin
                            r_idx <= '0;
                            if (!w_empty) begin
                                r_shift <= trace_pack(w_head);
                            end else begin
                                // Only the final byte remains, so the shift
                                // leaves o_tx_data at zero while idle.
                                r_shift <= r_shift >> 8;
                                r_valid <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 8;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_data  = r_shift[7:0];
    assign o_tx_valid = r_valid;

endmodule

// File: tb/tb_klp32_trace_tx.sv
`timescale 1ns/1ps
module tb_klp32_trace_tx;

    localparam int DEPTH = 8;
`ifdef KLP32_TRACE_ALUOUT_EN
    localparam int NB = 17;
`else
    localparam int NB = 13;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_capture_en = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_inst = '0;
    logic [31:0] i_writeBack = '0;
    logic [31:0] i_aluOut = '0;
    logic        i_RegWEn = 1'b0;
    logic        i_memRW = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_overflow;
    logic [3:0]  o_count;

    always #5 clk = ~clk;

    klp32_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_capture_en (i_capture_en),
        .i_pc         (i_pc),
        .i_inst       (i_inst),
        .i_writeBack  (i_writeBack),
        .i_aluOut     (i_aluOut),
        .i_RegWEn     (i_RegWEn),
        .i_memRW      (i_memRW),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_overflow   (o_overflow),
        .o_count      (o_count)
    );

    // Hand-computed stream for pc=4, inst=00500093, wb=5, alu=5, RegWEn=1.
    logic [7:0] exp1 [17] = '{8'hA1, 8'h04, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h50, 8'h00,
                              8'h05, 8'h00, 8'h00, 8'h00,
                              8'h05, 8'h00, 8'h00, 8'h00};

    logic [7:0] sb [$];
    int n_checks  = 0;
    int n_fails   = 0;
    int mon_bytes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bytes of one record: header, then each word LSB first.
    task automatic push_rec(input logic lost, input logic mrw, input logic rwe,
                            input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] wb, input logic [31:0] alu);
        logic [31:0] words [4];
        words = '{pc, inst, wb, alu};
        sb.push_back({4'hA, 1'b0, lost, mrw, rwe});
        for (int w = 0; w < NB / 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                sb.push_back(words[w][8*b +: 8]);
            end
        end
    endtask

    task automatic capture(input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] wb, input logic [31:0] alu,
                           input logic rwe, input logic mrw);
        i_pc         = pc;
        i_inst       = inst;
        i_writeBack  = wb;
        i_aluOut     = alu;
        i_RegWEn     = rwe;
        i_memRW      = mrw;
        i_capture_en = 1'b1;
        tick();
        i_capture_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({name, "_drain_remaining"}, sb.size(), 0);
    endtask

    // Monitor: consumes accepted bytes against the scoreboard and checks that
    // an offered byte stays put while the sink stalls.
    initial begin : monitor
        logic       hold;
        logic [7:0] hold_dat;
        logic [7:0] e;
        hold     = 1'b0;
        hold_dat = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", o_tx_valid, 1);
                    check("hold_data", o_tx_data, hold_dat);
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte", o_tx_data);
                    end else begin
                        e = sb.pop_front();
                        check("stream_byte", o_tx_data, e);
                    end
                    mon_bytes++;
                    hold = 1'b0;
                end else if (o_tx_valid) begin
                    hold     = 1'b1;
                    hold_dat = o_tx_data;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int run;
        int n;
        int base;
        logic [31:0] pc, inst, wb, alu;

        // Reset state
        repeat (3) tick();
        check("rst_valid", o_tx_valid, 0);
        check("rst_data", o_tx_data, 0);
        check("rst_count", o_count, 0);
        check("rst_overflow", o_overflow, 0);
        reset = 1'b1;
        tick();

        // Single record, sink always ready, latency checked
        i_tx_ready = 1'b1;
        for (int i = 0; i < NB; i++) sb.push_back(exp1[i]);
        capture(32'h0000_0004, 32'h0050_0093, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0);
        check("s1_count_after_capture", o_count, 1);
        check("s1_valid_before_pop", o_tx_valid, 0);
        tick();
        check("s1_valid_after_pop", o_tx_valid, 1);
        check("s1_count_after_pop", o_count, 0);
        wait_drain("s1", 100);
        check("s1_valid_idle", o_tx_valid, 0);
        check("s1_data_idle", o_tx_data, 0);

        // Ready toggling every cycle
        i_tx_ready = 1'b0;
        push_rec(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h00A1_2023, 32'h0000_0000, 32'hDEAD_BEEF);
        capture(32'h0000_0010, 32'h00A1_2023, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            i_tx_ready = ~i_tx_ready;
            tick();
            n++;
        end
        check("s2_drain_remaining", sb.size(), 0);
        tick();
        check("s2_valid_idle", o_tx_valid, 0);

        // Overflow: 12 captures with the sink stalled. One record moves into
        // the shift register, 8 fill the FIFO, the last 3 are dropped.
        i_tx_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            pc   = 32'h0000_0100 + 32'(4 * k);
            inst = 32'h1000_0000 + 32'(k);
            wb   = 32'h2000_0000 + 32'(3 * k);
            alu  = 32'h3000_0000 + 32'(k);
            if (k <= 9) push_rec(1'b0, k[1], k[0], pc, inst, wb, alu);
            capture(pc, inst, wb, alu, k[0], k[1]);
        end
        check("s3_count_full", o_count, DEPTH);
        check("s3_overflow", o_overflow, 1);
        i_tx_ready = 1'b1;
        repeat (25) tick();
        push_rec(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0013, 32'h0000_0007, 32'h0000_0008);
        capture(32'h0000_0200, 32'h0000_0013, 32'h0000_0007, 32'h0000_0008, 1'b1, 1'b0);
        wait_drain("s3", 400);
        check("s3_overflow_sticky", o_overflow, 1);
        check("s3_count_empty", o_count, 0);

        // Two records back to back
        push_rec(1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_CAFE);
        capture(32'h0000_0300, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_CAFE, 1'b1, 1'b0);
        push_rec(1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'h8765_4321, 32'h0000_00FF, 32'hFFFF_0000);
        capture(32'h0000_0304, 32'h8765_4321, 32'h0000_00FF, 32'hFFFF_0000, 1'b1, 1'b1);
        run = 0;
        while (o_tx_valid && run < 100) begin
            run++;
            tick();
        end
        check("s4_valid_run", run, 2 * NB);
        check("s4_drain_remaining", sb.size(), 0);

        // Reset in the middle of a record
        check("s5_overflow_before", o_overflow, 1);
        base = mon_bytes;
        push_rec(1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0073, 32'h1111_2222, 32'h3333_4444);
        capture(32'h0000_0400, 32'h0000_0073, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
        n = 0;
        while ((mon_bytes - base) < 5 && n < 100) begin
            tick();
            n++;
        end
        check("s5_bytes_before_reset", mon_bytes - base, 5);
        reset      = 1'b0;
        i_tx_ready = 1'b0;
        sb.delete();
        tick();
        check("s5_valid_after_reset", o_tx_valid, 0);
        check("s5_count_after_reset", o_count, 0);
        check("s5_overflow_after_reset", o_overflow, 0);
        check("s5_data_after_reset", o_tx_data, 0);
        reset      = 1'b1;
        i_tx_ready = 1'b1;
        push_rec(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h00B2_A023, 32'h5555_6666, 32'h7777_8888);
        capture(32'h0000_0500, 32'h00B2_A023, 32'h5555_6666, 32'h7777_8888, 1'b0, 1'b1);
        wait_drain("s5", 100);
        check("s5_valid_idle", o_tx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
